// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT back-end blocks.
// Holds the default sample format and bin count used by the FFT instances,
// and the state encoding of the bin serializer.
package fft_pkg;

   localparam int FFT_N    = 16;
   localparam int FFT_Q    = 8;
   localparam int FFT_BINS = 16;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } ser_state_e;

endpackage

// File: rtl/cplx_abs_sum.sv
// Combinational |re| + |im| magnitude estimate for one complex sample.
// Ports:
//   re, im : N-bit two's complement inputs
//   mag    : N+1-bit unsigned sum of absolute values
// Each absolute value fits an N-bit unsigned word, so |-2^(N-1)| = 2^(N-1)
// is exact.
// The extra output bit absorbs the carry, so the sum never wraps.
module cplx_abs_sum #(
   parameter int N = 16
) (
   input  logic [N-1:0] re,
   input  logic [N-1:0] im,
   output logic [N:0]   mag
);

   logic [N-1:0] abs_re;
   logic [N-1:0] abs_im;

   // Two's complement negate, read back as unsigned. The most negative value
   // maps onto itself, and read as unsigned that is the correct magnitude.
   assign abs_re = re[N-1] ? (~re + N'(1)) : re;
   assign abs_im = im[N-1] ? (~im + N'(1)) : im;

   assign mag = {1'b0, abs_re} + {1'b0, abs_im};

endmodule

// File: rtl/fft_bin_serializer.sv
// Captures one complex spectrum on the FFT's cycle-done pulse and streams the
// bins out in natural order over valid/ready, with |re|+|im| attached.
// Ports:
//   i_clk, i_rst           : clock, asynchronous active-low reset
//   i_frame_valid          : one-cycle frame pulse
//   i_bins_re, i_bins_im   : packed spectrum, bin k at [k*N +: N]
//   o_valid, i_ready       : output handshake
//   o_bin_re, o_bin_im     : current bin
//   o_bin_idx, o_mag       : bin index and magnitude estimate
//   o_last                 : marks bin BINS-1
//   o_busy                 : a captured frame is still draining
//   o_overrun, o_drop_cnt  : sticky drop flag and saturating drop counter
//   i_clr_overrun          : synchronous clear of the overrun status
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no frame held, waiting for i_frame_valid
// STREAM | shadow bank holds a frame, presenting shadow[index]
module fft_bin_serializer
   import fft_pkg::*;
#(
   parameter int N    = FFT_N,
   parameter int Q    = FFT_Q,
   parameter int BINS = FFT_BINS,
   parameter int IDXW = $clog2(FFT_BINS)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_frame_valid,
   input  logic [BINS*N-1:0] i_bins_re,
   input  logic [BINS*N-1:0] i_bins_im,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [N-1:0]      o_bin_re,
   output logic [N-1:0]      o_bin_im,
   output logic [IDXW-1:0]   o_bin_idx,
   output logic [N:0]        o_mag,
   output logic              o_last,
   output logic              o_busy,
   output logic              o_overrun,
   output logic [7:0]        o_drop_cnt,
   input  logic              i_clr_overrun
);

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BINS - 1);

   // Elaboration-time sanity checks on the parameter set; Q is carried only
   // so instances line up with the FFT blocks.
   if (BINS != (1 << IDXW)) begin : g_bad_bins
      $error("fft_bin_serializer: BINS must equal 2**IDXW");
   end
   if (Q >= N) begin : g_bad_q
      $error("fft_bin_serializer: Q must be smaller than N");
   end

   ser_state_e        state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [BINS*N-1:0] shadow_re, shadow_im;

   logic              xfer;
   logic              at_last;
   logic              capture;
   logic              load_out;
   logic              drop;

   logic [N-1:0]      sel_re, sel_im;
   logic [N:0]        sel_mag;

   assign xfer    = o_valid & i_ready;
   assign at_last = (idx_q == LAST_IDX);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      capture  = 1'b0;
      load_out = 1'b0;
      drop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_frame_valid) begin
               capture  = 1'b1;
               load_out = 1'b1;
               idx_d    = '0;
               state_d  = STREAM;
            end
         end
         STREAM: begin
            if (xfer && at_last) begin
               // A pulse landing on the final transfer is a seamless
               // follow-on frame, not an overrun.
               load_out = 1'b1;
               idx_d    = '0;
               if (i_frame_valid) begin
                  capture = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (xfer) begin
                  load_out = 1'b1;
                  idx_d    = idx_q + IDXW'(1);
               end
               drop = i_frame_valid;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Next presented bin: a fresh capture always starts at bin 0 straight from
   // the input bus, since the shadow bank is only written on this same edge.
   assign sel_re = capture ? i_bins_re[0 +: N] : shadow_re[idx_d*N +: N];
   assign sel_im = capture ? i_bins_im[0 +: N] : shadow_im[idx_d*N +: N];

   cplx_abs_sum #(
      .N (N)
   ) u_abs_sum (
      .re  (sel_re),
      .im  (sel_im),
      .mag (sel_mag)
   );

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         shadow_re <= '0;
         shadow_im <= '0;
      end else if (capture) begin
         shadow_re <= i_bins_re;
         shadow_im <= i_bins_im;
      end
   end

   // Output word only moves on capture or transfer, which keeps it frozen
   // through any stall.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_bin_re <= '0;
         o_bin_im <= '0;
         o_mag    <= '0;
         o_last   <= 1'b0;
      end else if (load_out) begin
         o_bin_re <= sel_re;
         o_bin_im <= sel_im;
         o_mag    <= sel_mag;
         o_last   <= (state_d == STREAM) && (idx_d == LAST_IDX);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_overrun  <= 1'b0;
         o_drop_cnt <= '0;
      end else if (drop) begin
         o_overrun  <= 1'b1;
         if (i_clr_overrun) begin
            o_drop_cnt <= 8'd1;
         end else if (o_drop_cnt != 8'hFF) begin
            o_drop_cnt <= o_drop_cnt + 8'd1;
         end
      end else if (i_clr_overrun) begin
         o_overrun  <= 1'b0;
         o_drop_cnt <= '0;
      end
   end

   assign o_valid   = (state_q == STREAM);
   assign o_busy    = (state_q == STREAM);
   assign o_bin_idx = idx_q;

endmodule
